seq_pattern_tx: RTL and testbench

Serial pattern transmitter: the driving end of the single-bit serial line sampled by the team's 0110 Mealy sequence detector. On a start request it shifts out a programmable PAT_W-bit pattern, MSB first, one bit per clock. The pattern is repeated a programmable number of times, with a programmable idle gap between repeats. Used as stimulus source and link driver for the detector path; a loopback of x into the detector is the primary system check.

---
 rtl/seq_pattern_tx.sv | 132 +++++++++++++
 tb/tb_seq_pattern_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a PAT_W-bit pattern out MSB first, repeated
// repeat_cnt times with gap idle bits between repeats. x, x_valid, busy and done are registered.
//
// state | meaning
// IDLE  | waiting for start, line idle
// SHIFT | driving pattern bits, one per clock
// GAP   | idle bits between repeats
// DONE  | one-cycle completion pulse, can accept a new start
module seq_pattern_tx #(
    parameter int   PAT_W    = 4,
    parameter int   CNT_W    = 4,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [CNT_W-1:0] gap,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int               IDX_W   = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t             state_q, state_n;
    logic [PAT_W-1:0]   pat_q, pat_n;
    logic [CNT_W-1:0]   rep_q, rep_n;
    logic [CNT_W-1:0]   gap_q, gap_n;
    logic [CNT_W-1:0]   gap_left_q, gap_left_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic               x_q, x_n;
    logic               x_valid_q, busy_q, done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            rep_q      <= '0;
            gap_q      <= '0;
            gap_left_q <= '0;
            idx_q      <= '0;
            x_q        <= IDLE_BIT;
            x_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            pat_q      <= pat_n;
            rep_q      <= rep_n;
            gap_q      <= gap_n;
            gap_left_q <= gap_left_n;
            idx_q      <= idx_n;
            x_q        <= x_n;
            x_valid_q  <= (state_n == SHIFT);
            busy_q     <= (state_n == SHIFT) || (state_n == GAP);
            done_q     <= (state_n == DONE);
        end
    end

    always_comb begin
        state_n    = state_q;
        pat_n      = pat_q;
        rep_n      = rep_q;
        gap_n      = gap_q;
        gap_left_n = gap_left_q;
        idx_n      = idx_q;
        x_n        = IDLE_BIT;
        case (state_q)
            IDLE, DONE: begin
                state_n = IDLE;
                if (start) begin
                    pat_n = pattern;
                    rep_n = repeat_cnt;
                    gap_n = gap;
                    if (repeat_cnt == '0) begin
                        state_n = DONE;
                    end else begin
                        state_n = SHIFT;
                        idx_n   = IDX_MSB;
                        x_n     = pattern[PAT_W-1];
                    end
                end
            end
            SHIFT: begin
                if (idx_q != '0) begin
                    idx_n = idx_q - IDX_ONE;
                    x_n   = pat_q[idx_q - IDX_ONE];
                end else if (rep_q > CNT_ONE) begin
                    rep_n = rep_q - CNT_ONE;
                    if (gap_q != '0) begin
                        state_n    = GAP;
                        gap_left_n = gap_q;
                    end else begin
                        // back-to-back repeat: next MSB follows the LSB directly
                        idx_n = IDX_MSB;
                        x_n   = pat_q[PAT_W-1];
                    end
                end else begin
                    rep_n   = '0;
                    state_n = DONE;
                end
            end
            GAP: begin
                if (gap_left_q == CNT_ONE) begin
                    state_n    = SHIFT;
                    gap_left_n = '0;
                    idx_n      = IDX_MSB;
                    x_n        = pat_q[PAT_W-1];
                end else begin
                    gap_left_n = gap_left_q - CNT_ONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign ready   = (state_q == IDLE) || (state_q == DONE);
    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: per-cycle line/status stream checked against a
// reference stream built from the request (pattern, repeats, gap).
`timescale 1ns/1ps
module tb_seq_pattern_tx;
    localparam int PAT_W = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic [CNT_W-1:0] gap;
    logic             ready, x, x_valid, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    // stream entries are {x, x_valid, busy, done, ready}
    logic [4:0] exp_q[$];
    logic [4:0] obs_q[$];

    seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .IDLE_BIT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
        .repeat_cnt(repeat_cnt), .gap(gap), .ready(ready), .x(x),
        .x_valid(x_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic void model_req(input logic [PAT_W-1:0] p, input int r, input int g,
                                      input bit tail_idle);
        for (int rr = 0; rr < r; rr++) begin
            for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({p[b], 4'b1100});
            if (rr < r - 1)
                for (int k = 0; k < g; k++) exp_q.push_back(5'b10100);
        end
        exp_q.push_back(5'b10011);
        if (tail_idle) exp_q.push_back(5'b10001);
    endfunction

    // Issue a request from IDLE and record n cycles starting the cycle after accept.
    // At index chain_at a second start with (cp, cr, cg) is driven.
    task automatic run_req(input logic [PAT_W-1:0] p, input int r, input int g, input int n,
                           input int chain_at, input logic [PAT_W-1:0] cp, input int cr,
                           input int cg);
        obs_q.delete();
        pattern    = p;
        repeat_cnt = CNT_W'(r);
        gap        = CNT_W'(g);
        start      = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            obs_q.push_back({x, x_valid, busy, done, ready});
            if (i == chain_at) begin
                pattern    = cp;
                repeat_cnt = CNT_W'(cr);
                gap        = CNT_W'(cg);
                start      = 1'b1;
            end else begin
                start      = 1'b0;
                pattern    = PAT_W'($urandom);
                repeat_cnt = CNT_W'($urandom);
                gap        = CNT_W'($urandom);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({x, x_valid, busy, done, ready} !== 5'b10001) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", {x, x_valid, busy, done, ready}, 5'b10001);
        end
    endtask

    task automatic test_single();
        exp_q.delete();
        model_req(4'b0110, 1, 0, 1'b1);
        run_req(4'b0110, 1, 0, exp_q.size(), -1, '0, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL single cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] hist;
        int         nbits;
        int         zpos[$];
        exp_q.delete();
        model_req(4'b0110, 2, 0, 1'b1);
        run_req(4'b0110, 2, 0, exp_q.size(), -1, '0, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
        hist  = '0;
        nbits = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i][3]) begin
                hist = {hist[2:0], obs_q[i][4]};
                nbits++;
                if (nbits >= 4 && hist == 4'b0110) zpos.push_back(nbits);
            end
        end
        n_tests++;
        if (zpos.size() != 2 || zpos[0] != 4 || zpos[1] != 8) begin
            n_fail++;
            $display("FAIL loopback_detect: got %0d hits (first %0d) expected hits at bits 4 and 8",
                     zpos.size(), (zpos.size() > 0) ? zpos[0] : -1);
        end
    endtask

    task automatic test_gap();
        int nbusy, ndone;
        exp_q.delete();
        model_req(4'b1001, 3, 2, 1'b1);
        run_req(4'b1001, 3, 2, exp_q.size(), -1, '0, 0, 0);
        nbusy = 0;
        ndone = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL gap cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
            nbusy += int'(obs_q[i][2]);
            ndone += int'(obs_q[i][1]);
        end
        n_tests++;
        if (nbusy != 16 || ndone != 1) begin
            n_fail++;
            $display("FAIL gap_counts: busy %0d done %0d expected busy 16 done 1", nbusy, ndone);
        end
    endtask

    task automatic test_zero_repeat();
        exp_q.delete();
        model_req(4'b1111, 0, 3, 1'b1);
        run_req(4'b1111, 0, 3, exp_q.size(), -1, '0, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL zero_repeat cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_ignored_start();
        exp_q.delete();
        model_req(4'b0110, 2, 1, 1'b1);
        run_req(4'b0110, 2, 1, exp_q.size(), 2, 4'b1111, 5, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ignored_start cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_in_done();
        exp_q.delete();
        model_req(4'b0110, 1, 0, 1'b0);
        model_req(4'b1010, 1, 0, 1'b1);
        run_req(4'b0110, 1, 0, exp_q.size(), 4, 4'b1010, 1, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL start_in_done cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [PAT_W-1:0] p;
        int               r, g;
        for (int t = 0; t < 12; t++) begin
            p = PAT_W'($urandom);
            r = (t == 0) ? 15 : int'($urandom_range(0, 4));
            g = (t == 0) ? 15 : int'($urandom_range(0, 3));
            exp_q.delete();
            model_req(p, r, g, 1'b1);
            run_req(p, r, g, exp_q.size(), -1, '0, 0, 0);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL random t%0d p=%b r=%0d g=%0d cycle %0d: got %b expected %b",
                             t, p, r, g, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        pattern    = 4'b0110;
        repeat_cnt = 4'd3;
        gap        = 4'd2;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        n_tests++;
        if (x_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_precondition: x_valid %b expected 1", x_valid);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({x, x_valid, busy, done, ready} !== 5'b10001) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b expected %b", {x, x_valid, busy, done, ready}, 5'b10001);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if ({x, x_valid, busy, done, ready} !== 5'b10001) begin
                n_fail++;
                $display("FAIL reset_mid_after cycle %0d: got %b expected %b",
                         i, {x, x_valid, busy, done, ready}, 5'b10001);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        pattern    = '0;
        repeat_cnt = '0;
        gap        = '0;
        #12;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_single();
        test_back_to_back();
        test_gap();
        test_zero_repeat();
        test_ignored_start();
        test_start_in_done();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
